// File: rtl/mem_bist_march_rw.sv
// March C- BIST initiator for one RW port of a register-file bank (async read, sync write).
// Define MBIST_CHECKERBOARD_EN to add a second march pass on a 0101.../1010... background.
module mem_bist_march_rw #(
  parameter int REG_DEPTH = 4,
  parameter int REG_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic [$clog2(REG_DEPTH)-1:0] fail_addr,
  output logic [2:0]                   fail_elem,
  output logic                         mem_wmode,
  output logic [$clog2(REG_DEPTH)-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]         mem_wdata,
  input  logic [REG_WIDTH-1:0]         mem_rdata
);
  localparam int AW = $clog2(REG_DEPTH);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_MAX  = AW'(REG_DEPTH - 1);
  localparam logic [2:0]    ELEM_LAST = 3'd5;
  localparam logic [REG_WIDTH-1:0] SOLID_BG = {REG_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_r;
  logic [2:0]             elem_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   fail_r;
  logic [AW-1:0]          fail_addr_r;
  logic [2:0]             fail_elem_r;
  logic                   mem_wmode_r;
  logic [AW-1:0]          mem_addr_r;
  logic [REG_WIDTH-1:0]   mem_wdata_r;

  logic [2:0]             nxt_elem_s;
  logic [AW-1:0]          nxt_addr_s;
  logic                   nxt_wr_s;
  logic [REG_WIDTH-1:0]   nxt_wdata_s;
  logic                   last_addr_s;
  logic                   end_of_pass_s;
  logic                   last_pass_s;
  logic [REG_WIDTH-1:0]   bg_s;
  logic [REG_WIDTH-1:0]   nxt_bg_s;
  logic [REG_WIDTH-1:0]   exp_s;
  logic                   mismatch_s;

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic rd_inv(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic wr_inv(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

`ifdef MBIST_CHECKERBOARD_EN
  function automatic logic [REG_WIDTH-1:0] checker_bg();
    logic [REG_WIDTH-1:0] v;
    for (int i = 0; i < REG_WIDTH; i++) begin
      v[i] = ((i % 2) == 0);
    end
    return v;
  endfunction

  localparam logic [REG_WIDTH-1:0] CHK_BG = checker_bg();
  logic pass_r;

  // Background pass tracker: solid first, checkerboard second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_r <= 1'b0;
    end else if ((state_r == S_IDLE) && start) begin
      pass_r <= 1'b0;
    end else if ((state_r == S_RUN) && end_of_pass_s && !pass_r) begin
      pass_r <= 1'b1;
    end else begin
      pass_r <= pass_r;
    end
  end

  assign bg_s        = pass_r ? CHK_BG : SOLID_BG;
  assign nxt_bg_s    = (pass_r || end_of_pass_s) ? CHK_BG : SOLID_BG;
  assign last_pass_s = pass_r;
`else
  assign bg_s        = SOLID_BG;
  assign nxt_bg_s    = SOLID_BG;
  assign last_pass_s = 1'b1;
`endif

  // Next-op sequencing and same-cycle read compare against the asynchronous rdata.
  always_comb begin
    nxt_elem_s    = elem_r;
    nxt_addr_s    = mem_addr_r;
    nxt_wr_s      = 1'b0;
    last_addr_s   = elem_down(elem_r) ? (mem_addr_r == ADDR_ZERO) : (mem_addr_r == ADDR_MAX);
    end_of_pass_s = (elem_r == ELEM_LAST) && last_addr_s;
    if (!mem_wmode_r && (elem_r != ELEM_LAST)) begin
      nxt_wr_s = 1'b1;
    end else if (!last_addr_s) begin
      nxt_addr_s = elem_down(elem_r) ? (mem_addr_r - ADDR_ONE) : (mem_addr_r + ADDR_ONE);
      nxt_wr_s   = (elem_r == 3'd0);
    end else if (elem_r != ELEM_LAST) begin
      nxt_elem_s = elem_r + 3'd1;
      nxt_addr_s = elem_down(elem_r + 3'd1) ? ADDR_MAX : ADDR_ZERO;
    end else begin
      // End of a pass that is not final: restart the march at E0.
      nxt_elem_s = 3'd0;
      nxt_addr_s = ADDR_ZERO;
      nxt_wr_s   = 1'b1;
    end
    if (nxt_wr_s) begin
      nxt_wdata_s = wr_inv(nxt_elem_s) ? ~nxt_bg_s : nxt_bg_s;
    end else begin
      nxt_wdata_s = SOLID_BG;
    end
    exp_s      = rd_inv(elem_r) ? ~bg_s : bg_s;
    mismatch_s = (state_r == S_RUN) && !mem_wmode_r && (mem_rdata != exp_s);
  end

  // Main sequencer: run state, registered port drive and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      elem_r      <= 3'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_addr_r <= ADDR_ZERO;
      fail_elem_r <= 3'd0;
      mem_wmode_r <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
      mem_wdata_r <= SOLID_BG;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= S_RUN;
            busy_r      <= 1'b1;
            fail_r      <= 1'b0;
            fail_addr_r <= ADDR_ZERO;
            fail_elem_r <= 3'd0;
            elem_r      <= 3'd0;
            mem_addr_r  <= ADDR_ZERO;
            mem_wmode_r <= 1'b1;
            mem_wdata_r <= SOLID_BG;
          end
        end
        S_RUN: begin
          if (mismatch_s) begin
            fail_r <= 1'b1;
            if (!fail_r) begin
              fail_addr_r <= mem_addr_r;
              fail_elem_r <= elem_r;
            end
          end
          if (end_of_pass_s && last_pass_s) begin
            state_r     <= S_DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            elem_r      <= 3'd0;
            mem_addr_r  <= ADDR_ZERO;
            mem_wmode_r <= 1'b0;
            mem_wdata_r <= SOLID_BG;
          end else begin
            elem_r      <= nxt_elem_s;
            mem_addr_r  <= nxt_addr_s;
            mem_wmode_r <= nxt_wr_s;
            mem_wdata_r <= nxt_wdata_s;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r     <= S_IDLE;
          elem_r      <= 3'd0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          mem_wmode_r <= 1'b0;
          mem_addr_r  <= ADDR_ZERO;
          mem_wdata_r <= SOLID_BG;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign fail      = fail_r;
  assign fail_addr = fail_addr_r;
  assign fail_elem = fail_elem_r;
  assign mem_wmode = mem_wmode_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_bist_march_rw.sv
// Scoreboarded bench for mem_bist_march_rw: 4x64 bank model with injectable stuck-at faults.
`timescale 1ns/1ps
module tb_mem_bist_march_rw;
  localparam int DEPTH = 4;
  localparam int WIDTH = 64;
`ifdef MBIST_CHECKERBOARD_EN
  localparam int RUN_CYC = 20 * DEPTH;
`else
  localparam int RUN_CYC = 10 * DEPTH;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, fail, mem_wmode;
  logic [1:0]       fail_addr, mem_addr;
  logic [2:0]       fail_elem;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;

  typedef struct {
    logic       f;
    logic [1:0] a;
    logic [2:0] e;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_pass   = 0;
  int         n_total  = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;
  logic       prev_done = 1'b0;
  logic [1:0] tr_addr [128];
  logic       tr_wr   [128];
  logic [63:0] tr_wd  [128];
  logic [63:0] mem [DEPTH];
  logic [63:0] s1  [DEPTH];
  logic [63:0] s0  [DEPTH];

  always #5 clk = ~clk;

  mem_bist_march_rw #(.REG_DEPTH(DEPTH), .REG_WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .mem_wmode (mem_wmode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Bank model: asynchronous read with stuck-at masks, synchronous write.
  assign mem_rdata = (mem[mem_addr] | s1[mem_addr]) & ~s0[mem_addr];
  always @(posedge clk) begin
    if (mem_wmode) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0 = done_cnt;
    int n  = 0;
    while (done_cnt == c0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_seen", done_cnt != c0, 1'b1);
  endtask

  task automatic wait_done_high(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_high_seen", done, 1'b1);
  endtask

  // Monitor: counts busy cycles, traces ops, and scores each run on its done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt  = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) check("done_width", done, 1'b0);
        if (busy) begin
          if (busy_cnt < 128) begin
            tr_addr[busy_cnt] = mem_addr;
            tr_wr[busy_cnt]   = mem_wmode;
            tr_wd[busy_cnt]   = mem_wdata;
          end
          busy_cnt++;
        end
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: done pulse with no run queued");
          end else begin
            e = exp_q.pop_front();
            check("busy_cycles", busy_cnt, e.cyc);
            check("fail",        fail,      e.f);
            check("fail_addr",   fail_addr, e.a);
            check("fail_elem",   fail_elem, e.e);
            check("busy_in_done", busy, 1'b0);
          end
          busy_cnt = 0;
        end
        prev_done = done;
      end
    end
  end

  initial begin : stim
    int c0;
    int e3a [8] = '{3, 3, 2, 2, 1, 1, 0, 0};
    for (int i = 0; i < DEPTH; i++) begin
      s1[i] = 64'h0;
      s0[i] = 64'h0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, fail, fail_addr, fail_elem, mem_wmode, mem_addr, mem_wdata}, 128'h0);
    rst_n = 1'b1;

    // 1: fault-free run
    exp_q.push_back('{1'b0, 2'd0, 3'd0, RUN_CYC});
    pulse_start();
    wait_done(RUN_CYC + 10);

    // 3: E3 trace from that run (ops 20..27)
    for (int k = 0; k < 8; k++) begin
      check($sformatf("e3_addr%0d", k), tr_addr[20 + k], e3a[k]);
      check($sformatf("e3_wmode%0d", k), tr_wr[20 + k], (k % 2));
      if ((k % 2) == 1) check($sformatf("e3_wdata%0d", k), tr_wd[20 + k], 64'hFFFF_FFFF_FFFF_FFFF);
    end

    // 2: bit 3 of address 2 stuck at 1
    s1[2] = 64'h8;
    exp_q.push_back('{1'b1, 2'd2, 3'd1, RUN_CYC});
    pulse_start();
    wait_done(RUN_CYC + 10);
    repeat (2) @(posedge clk);
    #1;
    check("fail_sticky", fail, 1'b1);

    // 4: reset at op 15 of a faulty run
    pulse_start();
    repeat (15) @(posedge clk);
    #1;
    check("pre_reset_fail", fail, 1'b1);
    check("pre_reset_wmode", mem_wmode, 1'b1);
    c0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy, fail, mem_wmode, fail_addr, fail_elem}, 8'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt - c0, 0);
    s1[2] = 64'h0;
    exp_q.push_back('{1'b0, 2'd0, 3'd0, RUN_CYC});
    pulse_start();
    wait_done(RUN_CYC + 10);

    // 5: start while busy and during DONE is ignored
    s1[2] = 64'h8;
    exp_q.push_back('{1'b1, 2'd2, 3'd1, RUN_CYC});
    c0 = done_cnt;
    pulse_start();
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done_high(RUN_CYC + 10);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("start_in_done_ignored", busy, 1'b0);
    check("fail_after_done", fail, 1'b1);
    repeat (RUN_CYC) @(posedge clk);
    #1;
    check("single_done", done_cnt - c0, 1);
    s1[2] = 64'h0;

    // 6: stuck-at-0 at address 0 bit 63, then restart right after done on a fixed bank
    s0[0] = 64'h8000_0000_0000_0000;
    exp_q.push_back('{1'b1, 2'd0, 3'd2, RUN_CYC});
    pulse_start();
    wait_done_high(RUN_CYC + 10);
    check("run6_fail_in_done", fail, 1'b1);
    s0[0] = 64'h0;
    exp_q.push_back('{1'b0, 2'd0, 3'd0, RUN_CYC});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("restart_busy", busy, 1'b1);
    check("restart_clears_fail", fail, 1'b0);
    wait_done(RUN_CYC + 10);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
